xst: RTL and testbench
======================

XST -- requirements
Module: xst

Interface
REQ-001 Parameter SHIFT_REG_WIDTH, default 64: transmit shift register width; SRW = SHIFT_REG_WIDTH-1.
REQ-002 clk_i  input  1  sole clock; all state changes on its rising edge.
REQ-003 reset_i  input  1  reset, synchronous, active-high.
REQ-004 bits_i  input  6  number of bits to send in a frame, sampled on start.
REQ-005 baud_i  input  64  clocks per bit minus one, sampled on start and at each bit boundary.
REQ-006 dat_i  input  64  parallel load data.
REQ-007 txreg_we_i  input  1  load shift register from dat_i, bit-for-bit.
REQ-008 txregr_we_i  input  1  load shift register from dat_i bit-reversed (reg[i] = dat_i[SRW-i]).
REQ-009 start_i  input  1  begin a frame.
REQ-010 txd_o  output  1  serial data, idles high.
REQ-011 txc_o  output  1  bit clock: high for the first half of every bit period.
REQ-012 idle_o  output  1  high when no frame is in progress.
REQ-013 bit_to  output  1  one-cycle pulse as each bit period ends.

Function
REQ-014 Shall hold shiftReg[SRW:0], bitsLeft[5:0], baudCtr[63:0], halfBaud[63:0]; idle_o = (bitsLeft == 0).
REQ-015 While idle, each write enable shall load shiftReg; if both are asserted, the result is the OR of the plain and reversed images.
REQ-016 Write enables asserted while busy shall be ignored.
REQ-017 start_i while idle with bits_i != 0 shall set bitsLeft = bits_i, baudCtr = baud_i, halfBaud = baud_i >> 1.
REQ-018 A write in the same cycle as a start shall be applied first, so the newly written data is transmitted.
REQ-019 start_i while busy, or with bits_i == 0, shall be ignored.
REQ-020 While busy with baudCtr != 0, baudCtr shall decrement by 1.
REQ-021 While busy with baudCtr == 0:
- shiftReg <= {1'b1, shiftReg[SRW:1]}
- bitsLeft decrements
- baudCtr reloads baud_i
- bit_to = 1 that cycle
REQ-022 Each bit shall last exactly baud_i+1 cycles; bits go LSB first.
REQ-023 The frame shall end (idle_o high) in the cycle after the last bit's bit_to.
REQ-024 txd_o = idle_o ? 1 : shiftReg[0]; loading while idle shall not disturb the line.
REQ-025 txc_o = ~idle_o && (baudCtr > halfBaud); each bit thus produces one rising edge at its start.
REQ-026 With baud_i == 0, txc_o shall stay low and one bit shall be sent per cycle.
REQ-027 bit_to shall be 0 while idle.

Reset
REQ-028 reset_i shall force:
- shiftReg all ones
- bitsLeft = 0
- baudCtr = baud_i
- halfBaud = 0
REQ-029 Outputs after reset shall be: txd_o=1, txc_o=0, idle_o=1, bit_to=0.
REQ-030 reset_i shall take priority over writes and start_i.
REQ-031 reset_i mid-frame shall abort the frame, with txd_o=1 and idle_o=1 on the following cycle.

Structure
REQ-032 No shared package; SRW is a local derived parameter.
REQ-033 Single module, no sub-modules.
REQ-034 The bit-reversal network shall be a generate loop.

Verification
REQ-035 txreg_we_i with dat_i=0xA, then start_i with bits_i=4, baud_i=3:
- txd_o = 0,1,0,1, each held 4 cycles
- bit_to pulses at cycles 4, 8, 12, 16 after start
- idle_o high after the fourth pulse
- txc_o high for 2 cycles of each bit
REQ-036 txregr_we_i with dat_i=0x8000_0000_0000_0000, then start with bits_i=1, baud_i=0 -> txd_o=1 for one cycle, then idle high.
REQ-037 Loopback (txd_o/txc_o into xsr rxd_i/rxc_i):
- both ends bits_i=8, baud_i=7
- transmit 0xC5
- xsr dat_o[63:56] == 0xC5 and xsr idle_o high after the frame
REQ-038 Busy-input rejection:
- second start_i and a txreg_we_i mid-frame -> frame length and bit values unchanged
- bits_i=0 start -> idle_o stays 1
REQ-039 reset_i at bit 3 of an 8-bit frame:
- next cycle txd_o=1, idle_o=1, txc_o=0
- a subsequent write and start transmits the new data correctly

Source files
------------

// File: rtl/xst.sv
// Serial transmitter: parallel-loaded shift register sent LSB first, with
// programmable bit length and a bit clock that is high for the first half of each bit.
module xst #(
    parameter int SHIFT_REG_WIDTH = 64
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [5:0]  bits_i,
    input  logic [63:0] baud_i,
    input  logic [63:0] dat_i,
    input  logic        txreg_we_i,
    input  logic        txregr_we_i,
    input  logic        start_i,
    output logic        txd_o,
    output logic        txc_o,
    output logic        idle_o,
    output logic        bit_to
);

    localparam int SRW = SHIFT_REG_WIDTH - 1;

    logic [SRW:0] shift_reg_q, shift_reg_d;
    logic [5:0]   bits_left_q, bits_left_d;
    logic [63:0]  baud_ctr_q,  baud_ctr_d;
    logic [63:0]  half_baud_q, half_baud_d;

    logic [SRW:0] rev_img;
    logic [SRW:0] load_img;

    for (genvar i = 0; i <= SRW; i++) begin : g_rev
        assign rev_img[i] = dat_i[SRW-i];
    end

    assign load_img = (txreg_we_i  ? dat_i[SRW:0] : '0)
                    | (txregr_we_i ? rev_img      : '0);

    assign idle_o = (bits_left_q == 6'd0);
    assign bit_to = ~idle_o && (baud_ctr_q == 64'd0);
    assign txd_o  = idle_o ? 1'b1 : shift_reg_q[0];
    assign txc_o  = ~idle_o && (baud_ctr_q > half_baud_q);

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latch).
        shift_reg_d = shift_reg_q;
        bits_left_d = bits_left_q;
        baud_ctr_d  = baud_ctr_q;
        half_baud_d = half_baud_q;

        if (reset_i) begin
            shift_reg_d = '1;
            bits_left_d = 6'd0;
            baud_ctr_d  = baud_i;
            half_baud_d = 64'd0;
        end else if (idle_o) begin
            // A write in the start cycle lands first, so the new data is what gets sent.
            if (txreg_we_i || txregr_we_i) begin
                shift_reg_d = load_img;
            end
            if (start_i && (bits_i != 6'd0)) begin
                bits_left_d = bits_i;
                baud_ctr_d  = baud_i;
                half_baud_d = baud_i >> 1;
            end
        end else if (baud_ctr_q != 64'd0) begin
            baud_ctr_d = baud_ctr_q - 64'd1;
        end else begin
            shift_reg_d = {1'b1, shift_reg_q[SRW:1]};
            bits_left_d = bits_left_q - 6'd1;
            baud_ctr_d  = baud_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; blocking here would race other flops.
    always_ff @(posedge clk_i) begin
        shift_reg_q <= shift_reg_d;
        bits_left_q <= bits_left_d;
        baud_ctr_q  <= baud_ctr_d;
        half_baud_q <= half_baud_d;
    end

endmodule

// File: tb/tb_xst.sv
// Directed self-checking bench for xst: reset, frame timing, load variants,
// busy-input rejection, bit-clock recovery and mid-frame reset.
module tb_xst;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [5:0]  bits_i;
    logic [63:0] baud_i;
    logic [63:0] dat_i;
    logic        txreg_we_i;
    logic        txregr_we_i;
    logic        start_i;
    logic        txd_o;
    logic        txc_o;
    logic        idle_o;
    logic        bit_to;

    int checks   = 0;
    int failures = 0;

    xst #(.SHIFT_REG_WIDTH(64)) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .bits_i      (bits_i),
        .baud_i      (baud_i),
        .dat_i       (dat_i),
        .txreg_we_i  (txreg_we_i),
        .txregr_we_i (txregr_we_i),
        .start_i     (start_i),
        .txd_o       (txd_o),
        .txc_o       (txc_o),
        .idle_o      (idle_o),
        .bit_to      (bit_to)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Caller has just clocked in the start; checks every cycle of the frame and
    // the idle cycle after it. A non-negative inj drives a start plus a write at that cycle.
    task automatic expect_frame(input int nbits, input int baud, input logic [63:0] pat, input int inj);
        int c;
        logic [63:0] ctr;
        c = 0;
        for (int b = 0; b < nbits; b++) begin
            for (int k = 0; k <= baud; k++) begin
                ctr = 64'(baud - k);
                if (c == inj) begin
                    start_i    = 1'b1;
                    bits_i     = 6'd8;
                    txreg_we_i = 1'b1;
                    dat_i      = 64'd0;
                end
                check($sformatf("txd b%0d k%0d", b, k), txd_o, pat[b]);
                check($sformatf("bit_to b%0d k%0d", b, k), bit_to, ctr == 64'd0);
                check($sformatf("txc b%0d k%0d", b, k), txc_o, ctr > 64'(baud / 2));
                check($sformatf("idle b%0d k%0d", b, k), idle_o, 1'b0);
                tick();
                start_i    = 1'b0;
                txreg_we_i = 1'b0;
                c++;
            end
        end
        check("end idle", idle_o, 1'b1);
        check("end txd", txd_o, 1'b1);
        check("end bit_to", bit_to, 1'b0);
    endtask

    task automatic load_start(input logic [63:0] dat, input logic plain, input logic rev,
                              input logic [5:0] nbits, input logic [63:0] baud);
        dat_i       = dat;
        txreg_we_i  = plain;
        txregr_we_i = rev;
        tick();
        txreg_we_i  = 1'b0;
        txregr_we_i = 1'b0;
        bits_i      = nbits;
        baud_i      = baud;
        start_i     = 1'b1;
        tick();
        start_i     = 1'b0;
    endtask

    initial begin : stimulus
        logic [7:0] rx;
        int         edges;
        int         cyc;
        logic       prev_txc;

        reset_i = 1'b1; bits_i = 6'd4; baud_i = 64'd5; dat_i = 64'd0;
        txreg_we_i = 1'b1; txregr_we_i = 1'b0; start_i = 1'b1;
        tick(); tick();
        reset_i = 1'b0; txreg_we_i = 1'b0; start_i = 1'b0;
        check("reset txd", txd_o, 1'b1);
        check("reset txc", txc_o, 1'b0);
        check("reset idle", idle_o, 1'b1);
        check("reset bit_to", bit_to, 1'b0);

        // Loading while idle must not disturb the line.
        dat_i = 64'hA; txreg_we_i = 1'b1;
        tick();
        txreg_we_i = 1'b0;
        check("load keeps txd", txd_o, 1'b1);
        check("load keeps idle", idle_o, 1'b1);
        bits_i = 6'd4; baud_i = 64'd3; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        expect_frame(4, 3, 64'b1010, -1);

        // Reversed load: dat[63] lands in bit 0; one-cycle bit with txc low.
        load_start(64'h8000_0000_0000_0000, 1'b0, 1'b1, 6'd1, 64'd0);
        expect_frame(1, 0, 64'b1, -1);

        // Both enables: OR of plain (bit1) and reversed (bit0) images.
        load_start(64'h8000_0000_0000_0002, 1'b1, 1'b1, 6'd2, 64'd0);
        expect_frame(2, 0, 64'b11, -1);

        // Write and start in the same cycle; mid-frame start/write ignored.
        dat_i = 64'h5; txreg_we_i = 1'b1; bits_i = 6'd3; baud_i = 64'd1; start_i = 1'b1;
        tick();
        txreg_we_i = 1'b0; start_i = 1'b0;
        expect_frame(3, 1, 64'b101, 2);

        // Zero-length start is ignored.
        bits_i = 6'd0; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("zero bits idle", idle_o, 1'b1);
        tick();
        check("zero bits idle later", idle_o, 1'b1);
        check("zero bits txd", txd_o, 1'b1);

        // Receive side: sample txd on each txc rising edge, LSB first.
        load_start(64'hC5, 1'b1, 1'b0, 6'd8, 64'd7);
        rx = 8'd0; edges = 0; cyc = 0; prev_txc = 1'b0;
        while (!idle_o && cyc < 200) begin
            if (txc_o && !prev_txc) begin
                rx = {txd_o, rx[7:1]};
                edges++;
            end
            prev_txc = txc_o;
            tick();
            cyc++;
        end
        check("loop timeout", cyc < 200, 1'b1);
        check("loop cycles", cyc, 64);
        check("loop edges", edges, 8);
        check("loop data", rx, 8'hC5);
        check("loop idle", idle_o, 1'b1);

        // Reset in bit 3 of an 8-bit all-zero frame.
        load_start(64'h0, 1'b1, 1'b0, 6'd8, 64'd3);
        repeat (13) tick();
        check("pre-reset txd", txd_o, 1'b0);
        check("pre-reset idle", idle_o, 1'b0);
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        check("abort txd", txd_o, 1'b1);
        check("abort idle", idle_o, 1'b1);
        check("abort txc", txc_o, 1'b0);
        check("abort bit_to", bit_to, 1'b0);
        load_start(64'h2, 1'b1, 1'b0, 6'd2, 64'd0);
        expect_frame(2, 0, 64'b10, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
